// File: rtl/stencil2d_window_feeder_if.sv
// Handshake bundle between a raster pixel source and the 3x3 window feeder.
//   in_valid/in_ready/in_data  : pixel stream, raster order, one pixel per accept
//   win_valid/win_ready        : window handshake toward the stencil MAC stage
//   win_data                   : 9 pixels, slice (k1*3+k2) = orig[r+k1][c+k2]
//   win_row/win_col            : top-left corner (r, c) of the window
//   win_last                   : final window of the frame
// master = pixel source / window consumer side, slave = window feeder.
interface stencil2d_window_feeder_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned COLS   = 64,
   parameter int unsigned ROWS   = 128
);
   localparam int unsigned ROW_W = $clog2(ROWS);
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned WIN_W = 9 * DATA_W;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              win_valid;
   logic              win_ready;
   logic [WIN_W-1:0]  win_data;
   logic [ROW_W-1:0]  win_row;
   logic [COL_W-1:0]  win_col;
   logic              win_last;

   modport master (
      output in_valid, in_data, win_ready,
      input  in_ready, win_valid, win_data, win_row, win_col, win_last
   );

   modport slave (
      input  in_valid, in_data, win_ready,
      output in_ready, win_valid, win_data, win_row, win_col, win_last
   );
endinterface

// File: rtl/stencil2d_window_feeder.sv
// Streaming 3x3 window generator for the 2D stencil datapath.
// Accepts one raster-order frame of ROWS x COLS pixels, keeps the two previous
// rows in line buffers and emits every complete 3x3 neighbourhood (top-left
// corner r in 0..ROWS-3, c in 0..COLS-3) as one wide word, in raster order.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of stencil2d_window_feeder_if (pixel in, window out)
// in_ready is combinational from the output register state and win_ready only.
module stencil2d_window_feeder #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned COLS   = 64,
   parameter int unsigned ROWS   = 128
) (
   input logic                      clk,
   input logic                      rst_n,
   stencil2d_window_feeder_if.slave bus
);

   localparam int unsigned ROW_W = $clog2(ROWS);
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned WIN_W = 9 * DATA_W;

   // Input position counters.
   logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
   logic [COL_W-1:0]  col_cnt_q, col_cnt_d;

   // Line buffers: lb0 holds row i-1, lb1 holds row i-2 (contents need no reset).
   logic [DATA_W-1:0] lb0_mem [COLS];
   logic [DATA_W-1:0] lb1_mem [COLS];

   // 3x3 column-shift window, indexed [k1][k2].
   logic [DATA_W-1:0] sh_q [3][3];
   logic [DATA_W-1:0] sh_d [3][3];

   // Single-entry output register.
   logic              win_valid_q, win_valid_d;
   logic              win_last_q,  win_last_d;
   logic [ROW_W-1:0]  win_row_q,   win_row_d;
   logic [COL_W-1:0]  win_col_q,   win_col_d;
   logic [WIN_W-1:0]  win_data_q,  win_data_d;

   logic              in_ready_c;
   logic              accept_c;
   logic              produce_c;
   logic              col_wrap_c;
   logic              row_wrap_c;
   logic [DATA_W-1:0] lb0_rd_c;
   logic [DATA_W-1:0] lb1_rd_c;

   // Handshake and per-pixel decode.
   always_comb begin
      in_ready_c = !win_valid_q || bus.win_ready;
      accept_c   = bus.in_valid && in_ready_c;
      col_wrap_c = (col_cnt_q == COL_W'(COLS - 1));
      row_wrap_c = (row_cnt_q == ROW_W'(ROWS - 1));
      produce_c  = accept_c && (row_cnt_q >= ROW_W'(2)) && (col_cnt_q >= COL_W'(2));
      lb0_rd_c   = lb0_mem[col_cnt_q];
      lb1_rd_c   = lb1_mem[col_cnt_q];
   end

   // Next-state: counters, shift window and output register.
   always_comb begin
      row_cnt_d   = row_cnt_q;
      col_cnt_d   = col_cnt_q;
      sh_d        = sh_q;
      win_valid_d = win_valid_q;
      win_last_d  = win_last_q;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      win_data_d  = win_data_q;

      if (accept_c) begin
         if (col_wrap_c) begin
            col_cnt_d = '0;
            row_cnt_d = row_wrap_c ? '0 : ROW_W'(row_cnt_q + ROW_W'(1));
         end else begin
            col_cnt_d = COL_W'(col_cnt_q + COL_W'(1));
         end

         // Shift columns left; the new column is {row i-2, row i-1, row i}.
         for (int k1 = 0; k1 < 3; k1++) begin
            for (int k2 = 0; k2 < 2; k2++) begin
               sh_d[k1][k2] = sh_q[k1][k2+1];
            end
         end
         sh_d[0][2] = lb1_rd_c;
         sh_d[1][2] = lb0_rd_c;
         sh_d[2][2] = bus.in_data;
      end

      // A new window replaces the entry; otherwise a consume empties it.
      if (produce_c) begin
         win_valid_d = 1'b1;
         win_row_d   = ROW_W'(row_cnt_q - ROW_W'(2));
         win_col_d   = COL_W'(col_cnt_q - COL_W'(2));
         win_last_d  = row_wrap_c && col_wrap_c;
         for (int k1 = 0; k1 < 3; k1++) begin
            for (int k2 = 0; k2 < 3; k2++) begin
               win_data_d[(k1*3 + k2)*DATA_W +: DATA_W] = sh_d[k1][k2];
            end
         end
      end else if (bus.win_ready) begin
         win_valid_d = 1'b0;
      end
   end

   // Control and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt_q   <= '0;
         col_cnt_q   <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
         win_data_q  <= '0;
         for (int k1 = 0; k1 < 3; k1++) begin
            for (int k2 = 0; k2 < 3; k2++) begin
               sh_q[k1][k2] <= '0;
            end
         end
      end else begin
         row_cnt_q   <= row_cnt_d;
         col_cnt_q   <= col_cnt_d;
         win_valid_q <= win_valid_d;
         win_last_q  <= win_last_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
         win_data_q  <= win_data_d;
         sh_q        <= sh_d;
      end
   end

   // Line buffers: row i-1 ages into row i-2 as row i overwrites it.
   always_ff @(posedge clk) begin
      if (accept_c) begin
         lb1_mem[col_cnt_q] <= lb0_rd_c;
         lb0_mem[col_cnt_q] <= bus.in_data;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.win_valid = win_valid_q;
   assign bus.win_last  = win_last_q;
   assign bus.win_row   = win_row_q;
   assign bus.win_col   = win_col_q;
   assign bus.win_data  = win_data_q;

endmodule

// File: tb/tb_stencil2d_window_feeder.sv
// Bench for stencil2d_window_feeder: a 4x4 instance for directed cases and a
// 64x128 instance for a random frame, both checked against a software 3x3
// extraction of the frame that was sent.
module tb_stencil2d_window_feeder;

   localparam int unsigned DW = 32;
   localparam int unsigned WW = 9 * DW;

   typedef struct {
      logic [WW-1:0] d;
      int            r;
      int            c;
      bit            last;
   } win_t;

   logic clk;
   logic rst_n;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] fr [128][64];
   win_t s_exp_q[$];
   win_t b_exp_q[$];
   int   s_got = 0;
   int   b_got = 0;
   bit   b_rand_ready = 0;

   stencil2d_window_feeder_if #(.DATA_W(DW), .COLS(4),  .ROWS(4))   sif ();
   stencil2d_window_feeder_if #(.DATA_W(DW), .COLS(64), .ROWS(128)) bif ();

   stencil2d_window_feeder #(.DATA_W(DW), .COLS(4), .ROWS(4)) u_small (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   stencil2d_window_feeder #(.DATA_W(DW), .COLS(64), .ROWS(128)) u_big (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [WW-1:0] pack9(input logic [DW-1:0] a0, a1, a2, a3, a4,
                                           a5, a6, a7, a8);
      return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   // Reference: every 3x3 neighbourhood of fr[0..rows-1][0..cols-1], raster order.
   task automatic model_frame(input int rows, input int cols, input bit big);
      win_t e;
      for (int r = 0; r <= rows - 3; r++) begin
         for (int c = 0; c <= cols - 3; c++) begin
            e.d = '0;
            for (int k1 = 0; k1 < 3; k1++)
               for (int k2 = 0; k2 < 3; k2++)
                  e.d[(k1*3 + k2)*DW +: DW] = fr[r+k1][c+k2];
            e.r    = r;
            e.c    = c;
            e.last = (r == rows - 3) && (c == cols - 3);
            if (big) b_exp_q.push_back(e);
            else     s_exp_q.push_back(e);
         end
      end
   endtask

   task automatic fill_small(input int base);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            fr[i][j] = DW'(base + i*4 + j);
   endtask

   task automatic cmp_win(input string tag, input win_t e, input logic [WW-1:0] d,
                          input int r, input int c, input bit l);
      chk({tag, "_data"}, d, e.d);
      chk({tag, "_row"},  WW'(r), WW'(e.r));
      chk({tag, "_col"},  WW'(c), WW'(e.c));
      chk({tag, "_last"}, WW'(l), WW'(e.last));
   endtask

   // Drive one pixel into the small instance; returns #1 after its accepting edge.
   task automatic s_send(input logic [DW-1:0] v);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      sif.in_valid = 1'b1;
      sif.in_data  = v;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = sif.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      sif.in_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL s_accept: pixel %0d not accepted within %0d cycles", v, n);
      end
   endtask

   task automatic b_send(input logic [DW-1:0] v);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      bif.in_valid = 1'b1;
      bif.in_data  = v;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = bif.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      bif.in_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL b_accept: pixel %0h not accepted within %0d cycles", v, n);
      end
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      sif.in_valid = 1'b0;
      bif.in_valid = 1'b0;
      s_exp_q.delete();
      s_got = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic s_drain(input string tag, input int want);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_count"},   WW'(s_got), WW'(want));
      chk({tag, "_pending"}, WW'(s_exp_q.size()), WW'(0));
   endtask

   // Small-instance compare process: consumed windows and hold stability.
   bit            s_hold = 0;
   logic [WW-1:0] s_pd;
   int            s_pr, s_pc;
   bit            s_pl;
   always @(negedge clk) begin
      win_t e;
      if (!rst_n) begin
         s_hold = 1'b0;
      end else begin
         if (s_hold) begin
            chk("s_hold_valid", WW'(sif.win_valid), WW'(1));
            chk("s_hold_data",  sif.win_data, s_pd);
            chk("s_hold_tags",  WW'({int'(sif.win_row), int'(sif.win_col), sif.win_last}),
                                WW'({s_pr, s_pc, s_pl}));
         end
         if (sif.win_valid && sif.win_ready) begin
            if (s_exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL s_extra: unexpected window r=%0d c=%0d", sif.win_row, sif.win_col);
            end else begin
               e = s_exp_q.pop_front();
               cmp_win("s_win", e, sif.win_data, int'(sif.win_row), int'(sif.win_col), sif.win_last);
            end
            s_got++;
         end
         s_hold = sif.win_valid && !sif.win_ready;
         s_pd   = sif.win_data;
         s_pr   = int'(sif.win_row);
         s_pc   = int'(sif.win_col);
         s_pl   = sif.win_last;
      end
   end

   // Big-instance compare process.
   bit            b_hold = 0;
   logic [WW-1:0] b_pd;
   int            b_pr, b_pc;
   bit            b_pl;
   always @(negedge clk) begin
      win_t e;
      if (!rst_n) begin
         b_hold = 1'b0;
      end else begin
         if (b_hold) begin
            chk("b_hold_valid", WW'(bif.win_valid), WW'(1));
            chk("b_hold_data",  bif.win_data, b_pd);
            chk("b_hold_tags",  WW'({int'(bif.win_row), int'(bif.win_col), bif.win_last}),
                                WW'({b_pr, b_pc, b_pl}));
         end
         if (bif.win_valid && bif.win_ready) begin
            if (b_exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL b_extra: unexpected window r=%0d c=%0d", bif.win_row, bif.win_col);
            end else begin
               e = b_exp_q.pop_front();
               cmp_win("b_win", e, bif.win_data, int'(bif.win_row), int'(bif.win_col), bif.win_last);
            end
            b_got++;
         end
         b_hold = bif.win_valid && !bif.win_ready;
         b_pd   = bif.win_data;
         b_pr   = int'(bif.win_row);
         b_pc   = int'(bif.win_col);
         b_pl   = bif.win_last;
      end
   end

   // Random consumer backpressure for the big instance.
   always @(posedge clk) begin
      if (b_rand_ready) begin
         #1;
         bif.win_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      sif.in_valid  = 1'b0;
      sif.in_data   = '0;
      sif.win_ready = 1'b1;
      bif.in_valid  = 1'b0;
      bif.in_data   = '0;
      bif.win_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state.
      chk("rst_valid",    WW'(sif.win_valid), WW'(0));
      chk("rst_last",     WW'(sif.win_last),  WW'(0));
      chk("rst_row",      WW'(sif.win_row),   WW'(0));
      chk("rst_col",      WW'(sif.win_col),   WW'(0));
      chk("rst_data",     sif.win_data,       WW'(0));
      chk("rst_in_ready", WW'(sif.in_ready),  WW'(1));
      chk("rst_b_valid",  WW'(bif.win_valid), WW'(0));

      // Single 4x4 frame, consumer always ready.
      fill_small(0);
      model_frame(4, 4, 1'b0);
      for (int p = 0; p < 16; p++) begin
         s_send(fr[p/4][p%4]);
         if (p == 10) begin
            chk("first_valid", WW'(sif.win_valid), WW'(1));
            chk("first_row",   WW'(sif.win_row),   WW'(0));
            chk("first_col",   WW'(sif.win_col),   WW'(0));
            chk("first_data",  sif.win_data, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
            chk("first_last",  WW'(sif.win_last),  WW'(0));
         end
         if (p == 15) begin
            chk("final_row",  WW'(sif.win_row),  WW'(1));
            chk("final_col",  WW'(sif.win_col),  WW'(1));
            chk("final_last", WW'(sif.win_last), WW'(1));
            chk("final_data", sif.win_data, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
         end
      end
      s_drain("frame1", 4);

      // Backpressure: hold the first window for five cycles.
      do_reset();
      fill_small(0);
      model_frame(4, 4, 1'b0);
      for (int p = 0; p <= 10; p++) s_send(fr[p/4][p%4]);
      sif.win_ready = 1'b0;
      sif.in_valid  = 1'b1;
      sif.in_data   = fr[2][3];
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_in_ready", WW'(sif.in_ready),  WW'(0));
         chk("bp_valid",    WW'(sif.win_valid), WW'(1));
         chk("bp_data",     sif.win_data, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
         @(posedge clk);
         #1;
      end
      sif.win_ready = 1'b1;
      for (int p = 11; p < 16; p++) s_send(fr[p/4][p%4]);
      s_drain("bp", 4);

      // Two frames back to back; second frame must not see first-frame data.
      do_reset();
      fill_small(0);
      model_frame(4, 4, 1'b0);
      for (int p = 0; p < 16; p++) s_send(fr[p/4][p%4]);
      fill_small(100);
      model_frame(4, 4, 1'b0);
      for (int p = 0; p < 16; p++) begin
         s_send(fr[p/4][p%4]);
         if (p == 10) begin
            chk("f2_row",  WW'(sif.win_row), WW'(0));
            chk("f2_col",  WW'(sif.win_col), WW'(0));
            chk("f2_data", sif.win_data, pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));
         end
      end
      s_drain("b2b", 8);

      // Reset after pixel 9 of a frame.
      do_reset();
      fill_small(0);
      for (int p = 0; p <= 9; p++) s_send(fr[p/4][p%4]);
      #1 rst_n = 1'b0;
      #1 chk("mid_rst_valid", WW'(sif.win_valid), WW'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset while a window is held: must drop before any clock edge.
      sif.win_ready = 1'b0;
      for (int p = 0; p <= 10; p++) s_send(fr[p/4][p%4]);
      chk("held_valid", WW'(sif.win_valid), WW'(1));
      #1 rst_n = 1'b0;
      #1;
      chk("async_valid",    WW'(sif.win_valid), WW'(0));
      chk("async_in_ready", WW'(sif.in_ready),  WW'(1));
      @(posedge clk);
      #1 rst_n = 1'b1;
      sif.win_ready = 1'b1;
      s_got = 0;

      // Fresh frame after reset starts at pixel (0,0).
      fill_small(200);
      model_frame(4, 4, 1'b0);
      for (int p = 0; p < 16; p++) begin
         s_send(fr[p/4][p%4]);
         if (p == 10) begin
            chk("fresh_valid", WW'(sif.win_valid), WW'(1));
            chk("fresh_data",  sif.win_data, pack9(200, 201, 202, 204, 205, 206, 208, 209, 210));
         end
      end
      s_drain("fresh", 4);

      // Default-size random frame with random valid and ready.
      for (int i = 0; i < 128; i++)
         for (int j = 0; j < 64; j++)
            fr[i][j] = $urandom;
      model_frame(128, 64, 1'b1);
      b_got = 0;
      b_rand_ready = 1'b1;
      for (int i = 0; i < 128; i++) begin
         for (int j = 0; j < 64; j++) begin
            while ($urandom_range(0, 3) == 0) begin
               bif.in_valid = 1'b0;
               bif.in_data  = $urandom;
               @(posedge clk);
               #1;
            end
            b_send(fr[i][j]);
         end
      end
      b_rand_ready = 1'b0;
      @(posedge clk);
      #2 bif.win_ready = 1'b1;
      for (int n = 0; n < 100 && b_exp_q.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("big_count",   WW'(b_got), WW'(7812));
      chk("big_pending", WW'(b_exp_q.size()), WW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
